// File: rtl/axi_wdata_router_pkg.sv
// Shared types for the AW-snooping write-data router. With AXI_WDATA_ROUTER_LEN_CHECK_EN
// defined, each grant entry also carries the burst length for the beat counter.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

package axi_wdata_router_pkg;

    typedef logic [1:0] msel_t;

    localparam logic [3:0] MCODE_M0 = 4'b0001;
    localparam logic [3:0] MCODE_M1 = 4'b0010;
    localparam logic [3:0] MCODE_M2 = 4'b0100;

    localparam msel_t SEL_M0 = 2'd0;
    localparam msel_t SEL_M1 = 2'd1;
    localparam msel_t SEL_M2 = 2'd2;

`ifdef AXI_WDATA_ROUTER_LEN_CHECK_EN
    typedef struct packed {
        msel_t                   sel;
        logic [`AXI_LEN_BITS-1:0] len;
    } grant_t;
`else
    typedef struct packed {
        msel_t sel;
    } grant_t;
`endif

endpackage

// File: rtl/axi_grant_fifo.sv
// In-order grant FIFO: one entry per accepted AW, popped at the end of the matching W burst.
module axi_grant_fifo
    import axi_wdata_router_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  grant_t din,
    output grant_t dout,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [PtrW:0]   count_q, count_d;
    grant_t          mem_q [DEPTH];
    grant_t          mem_d [DEPTH];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (push) begin
            mem_d[wptr_q] = din;
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout  = mem_q[rptr_q];
    assign full  = (count_q == (PtrW + 1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/axi_wdata_router.sv
// Steers the W channel of the AW-arbitration winner to the slave, in AW handshake order.
// Optional beat counter / WLAST check enabled by AXI_WDATA_ROUTER_LEN_CHECK_EN.
module axi_wdata_router
    import axi_wdata_router_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [`AXI_IDS_BITS-1:0]  AW_IDS,
    input  logic [`AXI_LEN_BITS-1:0]  AW_LEN,
    input  logic                      AW_VALID_M,
    output logic                      AW_READY_M,
    output logic                      AW_VALID_S,
    input  logic                      AW_READY_S,
    input  logic [`AXI_DATA_BITS-1:0] WDATA_M0,
    input  logic [`AXI_STRB_BITS-1:0] WSTRB_M0,
    input  logic                      WLAST_M0,
    input  logic                      WVALID_M0,
    output logic                      WREADY_M0,
    input  logic [`AXI_DATA_BITS-1:0] WDATA_M1,
    input  logic [`AXI_STRB_BITS-1:0] WSTRB_M1,
    input  logic                      WLAST_M1,
    input  logic                      WVALID_M1,
    output logic                      WREADY_M1,
    input  logic [`AXI_DATA_BITS-1:0] WDATA_M2,
    input  logic [`AXI_STRB_BITS-1:0] WSTRB_M2,
    input  logic                      WLAST_M2,
    input  logic                      WVALID_M2,
    output logic                      WREADY_M2,
    output logic [`AXI_DATA_BITS-1:0] WDATA_S,
    output logic [`AXI_STRB_BITS-1:0] WSTRB_S,
    output logic                      WLAST_S,
    output logic                      WVALID_S,
    input  logic                      WREADY_S,
    output logic                      W_ERR
);

    logic       full, empty, push, pop, w_hs, foreign, mst_last, routed;
    logic [3:0] mcode;
    msel_t      sel;
    grant_t     din, head;
    logic       unused_ids;

    assign mcode      = AW_IDS[`AXI_IDS_BITS-1 -: 4];
    assign unused_ids = ^AW_IDS[`AXI_IDS_BITS-5:0];

    always_comb begin
        sel     = SEL_M0;
        foreign = 1'b0;
        case (mcode)
            MCODE_M0: sel = SEL_M0;
            MCODE_M1: sel = SEL_M1;
            MCODE_M2: sel = SEL_M2;
            default:  foreign = 1'b1;
        endcase
    end

    assign AW_VALID_S = AW_VALID_M & ~full & ~rst;
    assign AW_READY_M = AW_READY_S & ~full & ~rst;
    // Foreign IDs are forwarded to the slave but never own the W channel.
    assign push       = AW_VALID_S & AW_READY_S & ~foreign;

    always_comb begin
        WDATA_S   = '0;
        WSTRB_S   = '0;
        WVALID_S  = 1'b0;
        WREADY_M0 = 1'b0;
        WREADY_M1 = 1'b0;
        WREADY_M2 = 1'b0;
        mst_last  = 1'b0;
        routed    = 1'b0;
        if (!empty) begin
            routed = 1'b1;
            case (head.sel)
                SEL_M0: begin
                    WDATA_S   = WDATA_M0;
                    WSTRB_S   = WSTRB_M0;
                    mst_last  = WLAST_M0;
                    WVALID_S  = WVALID_M0;
                    WREADY_M0 = WREADY_S;
                end
                SEL_M1: begin
                    WDATA_S   = WDATA_M1;
                    WSTRB_S   = WSTRB_M1;
                    mst_last  = WLAST_M1;
                    WVALID_S  = WVALID_M1;
                    WREADY_M1 = WREADY_S;
                end
                SEL_M2: begin
                    WDATA_S   = WDATA_M2;
                    WSTRB_S   = WSTRB_M2;
                    mst_last  = WLAST_M2;
                    WVALID_S  = WVALID_M2;
                    WREADY_M2 = WREADY_S;
                end
                default: routed = 1'b0;
            endcase
        end
    end

    assign w_hs = WVALID_S & WREADY_S;

`ifdef AXI_WDATA_ROUTER_LEN_CHECK_EN
    logic [`AXI_LEN_BITS-1:0] beat_q, beat_d;
    logic                     err_q, err_d;
    logic                     is_last;

    assign din     = '{sel: sel, len: AW_LEN};
    assign is_last = (beat_q == head.len);
    assign pop     = w_hs & is_last;
    assign WLAST_S = routed & is_last;
    assign W_ERR   = err_q;

    always_comb begin
        beat_d = beat_q;
        err_d  = err_q | (w_hs & (mst_last != is_last));
        if (pop) begin
            beat_d = '0;
        end else if (w_hs) begin
            beat_d = beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= '0;
            err_q  <= 1'b0;
        end else begin
            beat_q <= beat_d;
            err_q  <= err_d;
        end
    end
`else
    logic unused_len;

    assign unused_len = ^AW_LEN;
    assign din        = '{sel: sel};
    assign pop        = w_hs & mst_last;
    assign WLAST_S    = routed & mst_last;
    assign W_ERR      = 1'b0;
`endif

    axi_grant_fifo #(
        .DEPTH (DEPTH)
    ) u_grant_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_axi_wdata_router.sv
// Bench for axi_wdata_router: three modelled W masters, AW driver and an in-order beat scoreboard.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module tb_axi_wdata_router;

    typedef struct packed {
        logic [`AXI_DATA_BITS-1:0] data;
        logic [`AXI_STRB_BITS-1:0] strb;
        logic                      last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [`AXI_IDS_BITS-1:0]  AW_IDS = '0;
    logic [`AXI_LEN_BITS-1:0]  AW_LEN = '0;
    logic AW_VALID_M = 1'b0, AW_READY_M, AW_VALID_S, AW_READY_S = 1'b1;
    logic [`AXI_DATA_BITS-1:0] WDATA_S;
    logic [`AXI_STRB_BITS-1:0] WSTRB_S;
    logic WLAST_S, WVALID_S, WREADY_S = 1'b1, W_ERR;
    logic WREADY_M0, WREADY_M1, WREADY_M2;

    // Master models
    logic                      men [3] = '{1'b0, 1'b0, 1'b0};
    logic                      m_wready [3];
    logic                      m_pend [3];
    logic                      m_wlast [3];
    logic [`AXI_DATA_BITS-1:0] m_wdata [3];
    logic [`AXI_STRB_BITS-1:0] m_wstrb [3];
    logic [`AXI_LEN_BITS-1:0]  m_lens [3][16];
    int unsigned m_rd [3] = '{0, 0, 0};
    int unsigned m_wr [3] = '{0, 0, 0};
    int unsigned m_beat [3] = '{0, 0, 0};
    int unsigned m_seq [3] = '{0, 0, 0};
    int          m_last_at [3] = '{-1, -1, -1};
    logic        m_flush = 1'b0;

    // Scoreboard
    beat_t       exp_q [$];
    int unsigned exp_seq [3] = '{0, 0, 0};
    beat_t       obs [256];
    int unsigned obs_cyc [256];
    int unsigned obs_wr = 0;
    int unsigned obs_rd = 0;
    int unsigned cyc = 0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign m_wready[0] = WREADY_M0;
    assign m_wready[1] = WREADY_M1;
    assign m_wready[2] = WREADY_M2;

    axi_wdata_router #(
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .AW_IDS     (AW_IDS),
        .AW_LEN     (AW_LEN),
        .AW_VALID_M (AW_VALID_M),
        .AW_READY_M (AW_READY_M),
        .AW_VALID_S (AW_VALID_S),
        .AW_READY_S (AW_READY_S),
        .WDATA_M0   (m_wdata[0]),
        .WSTRB_M0   (m_wstrb[0]),
        .WLAST_M0   (m_wlast[0]),
        .WVALID_M0  (men[0]),
        .WREADY_M0  (WREADY_M0),
        .WDATA_M1   (m_wdata[1]),
        .WSTRB_M1   (m_wstrb[1]),
        .WLAST_M1   (m_wlast[1]),
        .WVALID_M1  (men[1]),
        .WREADY_M1  (WREADY_M1),
        .WDATA_M2   (m_wdata[2]),
        .WSTRB_M2   (m_wstrb[2]),
        .WLAST_M2   (m_wlast[2]),
        .WVALID_M2  (men[2]),
        .WREADY_M2  (WREADY_M2),
        .WDATA_S    (WDATA_S),
        .WSTRB_S    (WSTRB_S),
        .WLAST_S    (WLAST_S),
        .WVALID_S   (WVALID_S),
        .WREADY_S   (WREADY_S),
        .W_ERR      (W_ERR)
    );

    // Data tags the master, the beat index within its burst and its running beat count.
    always_comb begin
        for (int x = 0; x < 3; x++) begin
            m_pend[x]  = (m_rd[x] != m_wr[x]);
            m_wdata[x] = {4'(x), 4'h0, m_beat[x][7:0], m_seq[x][15:0]};
            m_wstrb[x] = 4'(1 << x);
            if (m_last_at[x] >= 0) begin
                m_wlast[x] = (int'(m_beat[x]) == m_last_at[x]);
            end else begin
                m_wlast[x] = m_pend[x] && (m_beat[x] == 32'(m_lens[x][m_rd[x] % 16]));
            end
        end
    end

    always @(posedge clk) begin
        for (int x = 0; x < 3; x++) begin
            if (m_flush) begin
                m_rd[x]   <= m_wr[x];
                m_beat[x] <= 0;
            end else if (men[x] && m_wready[x]) begin
                m_seq[x] <= m_seq[x] + 1;
                if (m_pend[x] && m_beat[x] == 32'(m_lens[x][m_rd[x] % 16])) begin
                    m_beat[x] <= 0;
                    m_rd[x]   <= m_rd[x] + 1;
                end else begin
                    m_beat[x] <= m_beat[x] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (WVALID_S && WREADY_S) begin
            obs[obs_wr % 256]     <= {WDATA_S, WSTRB_S, WLAST_S};
            obs_cyc[obs_wr % 256] <= cyc;
            obs_wr                <= obs_wr + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1);
    end

    task automatic register_aw(input logic [3:0] code, input logic [`AXI_LEN_BITS-1:0] len);
        int    x;
        beat_t e;
        case (code)
            4'b0001: x = 0;
            4'b0010: x = 1;
            4'b0100: x = 2;
            default: x = -1;
        endcase
        if (x >= 0) begin
            m_lens[x][m_wr[x] % 16] = len;
            m_wr[x]++;
            for (int k = 0; k <= int'(len); k++) begin
                e.data = {4'(x), 4'h0, 8'(k), 16'(exp_seq[x] + k)};
                e.strb = 4'(1 << x);
                e.last = (k == int'(len));
                exp_q.push_back(e);
            end
            exp_seq[x] += 32'(len) + 1;
        end
    endtask

    // Returns at the negedge just before the AW handshake edge.
    task automatic do_aw(input logic [3:0] code, input logic [`AXI_LEN_BITS-1:0] len);
        int n = 0;
        @(posedge clk); #1;
        AW_IDS     = {code, 4'h0};
        AW_LEN     = len;
        AW_VALID_M = 1'b1;
        @(negedge clk);
        while (!(AW_VALID_S && AW_READY_S) && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 20) begin
            n_fail++;
            $display("FAIL aw_handshake: code=%b got no handshake in 20 cycles, expected one", code);
        end else begin
            register_aw(code, len);
        end
    endtask

    task automatic aw_idle();
        @(posedge clk); #1;
        AW_VALID_M = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        AW_IDS = {4'b0010, 4'h0};
        AW_VALID_M = 1'b1;
        men = '{1'b1, 1'b1, 1'b1};
        @(negedge clk);
        n_checks++;
        if ({AW_VALID_S, AW_READY_M} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_aw: got valid_s/ready_m=%b, expected 00", {AW_VALID_S, AW_READY_M});
        end
        n_checks++;
        if ({WVALID_S, WREADY_M0, WREADY_M1, WREADY_M2, WLAST_S, W_ERR} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_w: got %b, expected 000000",
                     {WVALID_S, WREADY_M0, WREADY_M1, WREADY_M2, WLAST_S, W_ERR});
        end
        n_checks++;
        if ({WDATA_S, WSTRB_S} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h, expected 0/0", WDATA_S, WSTRB_S);
        end
        AW_VALID_M = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({AW_READY_M, WVALID_S, WREADY_M0, WREADY_M1, WREADY_M2} !== 5'b10000) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b, expected 10000",
                     {AW_READY_M, WVALID_S, WREADY_M0, WREADY_M1, WREADY_M2});
        end
        men = '{1'b0, 1'b0, 1'b0};
    endtask

    task automatic test_single();
        beat_t e;
        logic  bad = 1'b0;
        men = '{1'b1, 1'b1, 1'b1};
        do_aw(4'b0010, 4'd3);
        aw_idle();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (WREADY_M0 || WREADY_M2) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL single_other_ready: got WREADY_M0/M2 high, expected low");
        end
        n_checks++;
        if ({WVALID_S, WREADY_M1} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_empty: got valid/ready=%b, expected 00", {WVALID_S, WREADY_M1});
        end
        #2;
        while (obs_rd != obs_wr) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL single_extra: got beat %h, expected none", obs[obs_rd % 256].data);
            end else begin
                e = exp_q.pop_front();
                if (obs[obs_rd % 256] !== e) begin
                    n_fail++;
                    $display("FAIL single_beat: got %h, expected %h", obs[obs_rd % 256], e);
                end
            end
            obs_rd++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_missing: got %0d beats left, expected 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        beat_t       e;
        int unsigned base = obs_wr;
        men = '{1'b1, 1'b1, 1'b1};
        do_aw(4'b0001, 4'd0);
        do_aw(4'b0100, 4'd1);
        do_aw(4'b0010, 4'd0);
        aw_idle();
        repeat (6) @(negedge clk);
        #2;
        n_checks++;
        if (obs_wr - base != 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d beats, expected 4", obs_wr - base);
        end else begin
            n_checks++;
            if (obs_cyc[(base + 3) % 256] - obs_cyc[base % 256] != 3) begin
                n_fail++;
                $display("FAIL b2b_span: got %0d cycles, expected 3",
                         obs_cyc[(base + 3) % 256] - obs_cyc[base % 256]);
            end
        end
        while (obs_rd != obs_wr) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL b2b_extra: got beat %h, expected none", obs[obs_rd % 256].data);
            end else begin
                e = exp_q.pop_front();
                if (obs[obs_rd % 256] !== e) begin
                    n_fail++;
                    $display("FAIL b2b_beat: got %h, expected %h", obs[obs_rd % 256], e);
                end
            end
            obs_rd++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_missing: got %0d beats left, expected 0", exp_q.size());
        end
    endtask

    task automatic test_full();
        beat_t e;
        men = '{1'b0, 1'b0, 1'b0};
        do_aw(4'b0001, 4'd0);
        do_aw(4'b0010, 4'd0);
        do_aw(4'b0100, 4'd0);
        do_aw(4'b0001, 4'd1);
        @(posedge clk); #1;
        AW_IDS = {4'b0010, 4'h0};
        AW_LEN = 4'd0;
        @(negedge clk);
        n_checks++;
        if ({AW_READY_M, AW_VALID_S} !== 2'b00) begin
            n_fail++;
            $display("FAIL full_stall: got ready_m/valid_s=%b, expected 00", {AW_READY_M, AW_VALID_S});
        end
        @(posedge clk); #1;
        men[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({WREADY_M0, AW_READY_M} !== 2'b10) begin
            n_fail++;
            $display("FAIL full_pop_cycle: got wready_m0/aw_ready_m=%b, expected 10",
                     {WREADY_M0, AW_READY_M});
        end
        @(negedge clk);
        n_checks++;
        if ({AW_READY_M, AW_VALID_S} !== 2'b11) begin
            n_fail++;
            $display("FAIL full_resume: got ready_m/valid_s=%b, expected 11", {AW_READY_M, AW_VALID_S});
        end else begin
            register_aw(4'b0010, 4'd0);
        end
        aw_idle();
        men = '{1'b1, 1'b1, 1'b1};
        repeat (10) @(negedge clk);
        #2;
        while (obs_rd != obs_wr) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL full_extra: got beat %h, expected none", obs[obs_rd % 256].data);
            end else begin
                e = exp_q.pop_front();
                if (obs[obs_rd % 256] !== e) begin
                    n_fail++;
                    $display("FAIL full_beat: got %h, expected %h", obs[obs_rd % 256], e);
                end
            end
            obs_rd++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL full_missing: got %0d beats left, expected 0", exp_q.size());
        end
    endtask

    task automatic test_aw_to_w();
        beat_t e;
        men = '{1'b1, 1'b0, 1'b0};
        do_aw(4'b0001, 4'd0);
        n_checks++;
        if (WREADY_M0 !== 1'b0) begin
            n_fail++;
            $display("FAIL aw_cycle_ready: got WREADY_M0=%b, expected 0", WREADY_M0);
        end
        aw_idle();
        @(negedge clk);
        n_checks++;
        if (WREADY_M0 !== 1'b1) begin
            n_fail++;
            $display("FAIL next_cycle_ready: got WREADY_M0=%b, expected 1", WREADY_M0);
        end
        repeat (2) @(negedge clk);
        #2;
        while (obs_rd != obs_wr) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL lat_extra: got beat %h, expected none", obs[obs_rd % 256].data);
            end else begin
                e = exp_q.pop_front();
                if (obs[obs_rd % 256] !== e) begin
                    n_fail++;
                    $display("FAIL lat_beat: got %h, expected %h", obs[obs_rd % 256], e);
                end
            end
            obs_rd++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL lat_missing: got %0d beats left, expected 0", exp_q.size());
        end
    endtask

    task automatic test_foreign();
        logic bad = 1'b0;
        men = '{1'b1, 1'b1, 1'b1};
        do_aw(4'b1000, 4'd3);
        aw_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (WVALID_S || WREADY_M0 || WREADY_M1 || WREADY_M2) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL foreign_no_grant: got W routed, expected no grant");
        end
        #2;
        n_checks++;
        if (obs_rd != obs_wr) begin
            n_fail++;
            $display("FAIL foreign_beats: got %0d beats, expected 0", obs_wr - obs_rd);
            obs_rd = obs_wr;
        end
        men = '{1'b0, 1'b0, 1'b0};
    endtask

`ifdef AXI_WDATA_ROUTER_LEN_CHECK_EN
    task automatic test_len_check();
        beat_t e;
        men = '{1'b0, 1'b0, 1'b0};
        m_last_at[0] = 1;
        do_aw(4'b0001, 4'd2);
        aw_idle();
        men[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({WLAST_S, W_ERR} !== 2'b00) begin
            n_fail++;
            $display("FAIL len_beat0: got wlast/err=%b, expected 00", {WLAST_S, W_ERR});
        end
        @(negedge clk);
        n_checks++;
        if ({WLAST_S, W_ERR} !== 2'b00) begin
            n_fail++;
            $display("FAIL len_beat1: got wlast/err=%b, expected 00", {WLAST_S, W_ERR});
        end
        @(negedge clk);
        n_checks++;
        if ({WLAST_S, W_ERR, WREADY_M0} !== 3'b111) begin
            n_fail++;
            $display("FAIL len_beat2: got wlast/err/ready=%b, expected 111",
                     {WLAST_S, W_ERR, WREADY_M0});
        end
        @(negedge clk);
        n_checks++;
        if ({WVALID_S, W_ERR} !== 2'b01) begin
            n_fail++;
            $display("FAIL len_popped: got valid_s/err=%b, expected 01", {WVALID_S, W_ERR});
        end
        m_last_at[0] = -1;
        men[0] = 1'b0;
        #2;
        while (obs_rd != obs_wr) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL len_extra: got beat %h, expected none", obs[obs_rd % 256].data);
            end else begin
                e = exp_q.pop_front();
                if (obs[obs_rd % 256] !== e) begin
                    n_fail++;
                    $display("FAIL len_beat: got %h, expected %h", obs[obs_rd % 256], e);
                end
            end
            obs_rd++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL len_missing: got %0d beats left, expected 0", exp_q.size());
        end
    endtask
`endif

    task automatic test_reset_mid_burst();
        beat_t e;
        logic  bad = 1'b0;
        men = '{1'b1, 1'b0, 1'b0};
        do_aw(4'b0001, 4'd7);
        aw_idle();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({WVALID_S, WDATA_S[23:16]} !== {1'b1, 8'd2}) begin
            n_fail++;
            $display("FAIL rstmid_beat2: got valid=%b beat=%0d, expected 1/2", WVALID_S, WDATA_S[23:16]);
        end
        rst = 1'b1;
        AW_IDS = {4'b0010, 4'h0};
        AW_VALID_M = 1'b1;
        #1;
        n_checks++;
        if ({AW_VALID_S, AW_READY_M, WVALID_S, WREADY_M0, WLAST_S, W_ERR, WDATA_S, WSTRB_S} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got aw=%b w=%b data=%h strb=%h, expected all 0",
                     {AW_VALID_S, AW_READY_M}, {WVALID_S, WREADY_M0, WLAST_S, W_ERR}, WDATA_S, WSTRB_S);
        end
        AW_VALID_M = 1'b0;
        #2;
        while (obs_rd != obs_wr) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rstmid_extra: got beat %h, expected none", obs[obs_rd % 256].data);
            end else begin
                e = exp_q.pop_front();
                if (obs[obs_rd % 256] !== e) begin
                    n_fail++;
                    $display("FAIL rstmid_beat: got %h, expected %h", obs[obs_rd % 256], e);
                end
            end
            obs_rd++;
        end
        exp_q.delete();
        m_flush = 1'b1;
        @(posedge clk); #1;
        m_flush = 1'b0;
        for (int x = 0; x < 3; x++) exp_seq[x] = m_seq[x];
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (WREADY_M0 || WVALID_S) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_stale: got WREADY_M0/WVALID_S high, expected low");
        end
        men[2] = 1'b1;
        do_aw(4'b0100, 4'd1);
        aw_idle();
        repeat (4) @(negedge clk);
        n_checks++;
        if ({WVALID_S, W_ERR} !== 2'b00) begin
            n_fail++;
            $display("FAIL rstmid_after: got valid_s/err=%b, expected 00", {WVALID_S, W_ERR});
        end
        #2;
        while (obs_rd != obs_wr) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rstmid_m2_extra: got beat %h, expected none", obs[obs_rd % 256].data);
            end else begin
                e = exp_q.pop_front();
                if (obs[obs_rd % 256] !== e) begin
                    n_fail++;
                    $display("FAIL rstmid_m2_beat: got %h, expected %h", obs[obs_rd % 256], e);
                end
            end
            obs_rd++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_m2_missing: got %0d beats left, expected 0", exp_q.size());
        end
        men = '{1'b0, 1'b0, 1'b0};
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_aw_to_w();
        test_foreign();
`ifdef AXI_WDATA_ROUTER_LEN_CHECK_EN
        test_len_check();
`endif
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
